dual_port_ram: RTL and testbench

Byte-addressed, two-port Wishbone secondary RAM with per-port programmable wait states and byte-lane enables. Each port runs its own handshake independently. Both ports share one byte array, so the CPU instruction and data buses, or a CPU and a DMA engine, can reach one memory. It is the parametrised, dual-channel successor to the single-port memory and keeps the same lane/offset addressing model.

---
 rtl/dual_port_ram_pkg.sv | 23 ++
 rtl/dual_port_ram_ctrl.sv | 103 ++++++++++
 rtl/dual_port_ram.sv | 102 ++++++++++
 tb/tb_dual_port_ram.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dual_port_ram_pkg.sv
// Shared definitions for the dual-port byte RAM: port FSM states,
// wait-state limits and the latency clamp used by each port controller.
package dual_port_ram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } port_state_e;

  localparam int unsigned LATENCY_MIN = 1;
  localparam int unsigned LATENCY_MAX = 15;
  localparam int unsigned CNT_WIDTH   = $clog2(16);

  // Out-of-range latencies are pulled back into the supported window so the
  // wait-state counter can never be loaded with a value it cannot hold.
  function automatic int unsigned clamp_latency(input int unsigned lat);
    if (lat < LATENCY_MIN) return LATENCY_MIN;
    if (lat > LATENCY_MAX) return LATENCY_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/dual_port_ram_ctrl.sv
// Per-port Wishbone handshake: IDLE/BUSY/ACK FSM, wait-state counter,
// request latches, registered ack and read data that is zero outside ack.
module ram_port_ctrl
  import dual_port_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LATENCY    = 3
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    i_cyc,
  input  logic                    i_stb,
  input  logic [DATA_WIDTH/8-1:0] i_sel,
  input  logic [DATA_WIDTH-1:0]   i_rd_word,
  output logic                    o_accept,
  output logic [DATA_WIDTH-1:0]   o_dat,
  output logic                    o_ack
);

  localparam int unsigned SEL_W = DATA_WIDTH / 8;
  localparam int unsigned LAT   = clamp_latency(LATENCY);
  localparam logic [CNT_WIDTH-1:0] CNT_LOAD =
    (LAT > 1) ? CNT_WIDTH'(LAT - 2) : '0;

  port_state_e             r_state;
  port_state_e             w_next;
  logic                    w_accept;
  logic [CNT_WIDTH-1:0]    r_cnt;
  logic [SEL_W-1:0]        r_sel;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic [DATA_WIDTH-1:0]   r_dat;
  logic                    r_ack;
  logic [DATA_WIDTH-1:0]   w_live_masked;
  logic [DATA_WIDTH-1:0]   w_held_masked;

  // Next-state decode; only an idle port accepts a request.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_cyc && i_stb) begin
          w_accept = 1'b1;
          w_next   = (LAT == 1) ? ST_ACK : ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (r_cnt == '0) w_next = ST_ACK;
      end
      ST_ACK:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Lane masking of the read word: live for single-cycle latency, held otherwise.
  always_comb begin
    w_live_masked = '0;
    w_held_masked = '0;
    for (int unsigned i = 0; i < SEL_W; i++) begin
      w_live_masked[8*i +: 8] = i_sel[i] ? i_rd_word[8*i +: 8] : 8'h00;
      w_held_masked[8*i +: 8] = r_sel[i] ? r_rdata[8*i +: 8]   : 8'h00;
    end
  end

  // State register, wait-state counter and request latches.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_sel   <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt   <= CNT_LOAD;
        r_sel   <= i_sel;
        r_rdata <= i_rd_word;
      end else if (r_state == ST_BUSY && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // Registered ack and read data; data is forced to zero whenever ack is low.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= (w_next == ST_ACK);
      if (w_next == ST_ACK) begin
        r_dat <= w_accept ? w_live_masked : w_held_masked;
      end else begin
        r_dat <= '0;
      end
    end
  end

  assign o_accept = w_accept;
  assign o_ack    = r_ack;
  assign o_dat    = r_dat;

endmodule

// File: rtl/dual_port_ram.sv
// Two-port Wishbone byte RAM sharing one byte array. Each port has its own
// controller; on same-edge byte collisions port A's write wins and reads
// always see the data stored before the edge.
module dual_port_ram
  import dual_port_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned LATENCY_A  = 3,
  parameter int unsigned LATENCY_B  = 3,
  parameter              INIT_FILE  = ""
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    a_cyc,
  input  logic                    a_stb,
  input  logic                    a_we,
  input  logic [DATA_WIDTH/8-1:0] a_sel,
  input  logic [ADDR_WIDTH-1:0]   a_addr,
  input  logic [DATA_WIDTH-1:0]   a_dat_i,
  output logic [DATA_WIDTH-1:0]   a_dat_o,
  output logic                    a_ack,
  input  logic                    b_cyc,
  input  logic                    b_stb,
  input  logic                    b_we,
  input  logic [DATA_WIDTH/8-1:0] b_sel,
  input  logic [ADDR_WIDTH-1:0]   b_addr,
  input  logic [DATA_WIDTH-1:0]   b_dat_i,
  output logic [DATA_WIDTH-1:0]   b_dat_o,
  output logic                    b_ack
);

  localparam int unsigned SEL_W = DATA_WIDTH / 8;
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [7:0]            r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] w_a_lane_addr [SEL_W];
  logic [ADDR_WIDTH-1:0] w_b_lane_addr [SEL_W];
  logic [DATA_WIDTH-1:0] w_a_rd_word;
  logic [DATA_WIDTH-1:0] w_b_rd_word;
  logic                  w_a_accept;
  logic                  w_b_accept;

  // Lane address generation (wrapping modulo depth) and raw read muxes.
  always_comb begin
    w_a_lane_addr = '{default: '0};
    w_b_lane_addr = '{default: '0};
    w_a_rd_word   = '0;
    w_b_rd_word   = '0;
    for (int unsigned i = 0; i < SEL_W; i++) begin
      w_a_lane_addr[i]        = a_addr + ADDR_WIDTH'(i);
      w_b_lane_addr[i]        = b_addr + ADDR_WIDTH'(i);
      w_a_rd_word[8*i +: 8]   = r_mem[w_a_lane_addr[i]];
      w_b_rd_word[8*i +: 8]   = r_mem[w_b_lane_addr[i]];
    end
  end

  // Byte-lane writes at acceptance; A is applied last so it wins a collision.
  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < SEL_W; i++) begin
      if (w_b_accept && b_we && b_sel[i]) begin
        r_mem[w_b_lane_addr[i]] <= b_dat_i[8*i +: 8];
      end
    end
    for (int unsigned i = 0; i < SEL_W; i++) begin
      if (w_a_accept && a_we && a_sel[i]) begin
        r_mem[w_a_lane_addr[i]] <= a_dat_i[8*i +: 8];
      end
    end
  end

  ram_port_ctrl #(
    .DATA_WIDTH (DATA_WIDTH),
    .LATENCY    (LATENCY_A)
  ) u_port_a (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_cyc     (a_cyc),
    .i_stb     (a_stb),
    .i_sel     (a_sel),
    .i_rd_word (w_a_rd_word),
    .o_accept  (w_a_accept),
    .o_dat     (a_dat_o),
    .o_ack     (a_ack)
  );

  ram_port_ctrl #(
    .DATA_WIDTH (DATA_WIDTH),
    .LATENCY    (LATENCY_B)
  ) u_port_b (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_cyc     (b_cyc),
    .i_stb     (b_stb),
    .i_sel     (b_sel),
    .i_rd_word (w_b_rd_word),
    .o_accept  (w_b_accept),
    .o_dat     (b_dat_o),
    .o_ack     (b_ack)
  );

endmodule

// File: tb/tb_dual_port_ram.sv
// Bench for dual_port_ram with port A at 3 wait cycles and port B at 1.
module tb_dual_port_ram;

  localparam int LAT_A = 3;
  localparam int LAT_B = 1;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        a_cyc, a_stb, a_we, b_cyc, b_stb, b_we;
  logic [3:0]  a_sel, b_sel;
  logic [11:0] a_addr, b_addr;
  logic [31:0] a_dat_i, b_dat_i, a_dat_o, b_dat_o;
  logic        a_ack, b_ack;

  bit [7:0] mem_model [4096];
  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  dual_port_ram #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (12),
    .LATENCY_A  (LAT_A),
    .LATENCY_B  (LAT_B),
    .INIT_FILE  ("")
  ) dut (
    .clock   (clock),   .reset_n (reset_n),
    .a_cyc   (a_cyc),   .a_stb   (a_stb),   .a_we    (a_we),
    .a_sel   (a_sel),   .a_addr  (a_addr),  .a_dat_i (a_dat_i),
    .a_dat_o (a_dat_o), .a_ack   (a_ack),
    .b_cyc   (b_cyc),   .b_stb   (b_stb),   .b_we    (b_we),
    .b_sel   (b_sel),   .b_addr  (b_addr),  .b_dat_i (b_dat_i),
    .b_dat_o (b_dat_o), .b_ack   (b_ack)
  );

  // Reference model: a flat byte array, lane i at (addr+i) mod 4096.
  function automatic logic [31:0] model_read(input logic [11:0] ad, input logic [3:0] s);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      logic [11:0] la;
      la = ad + 12'(i);
      if (s[i]) r[8*i +: 8] = mem_model[la];
    end
    return r;
  endfunction

  task automatic model_write(input logic [11:0] ad, input logic [3:0] s, input logic [31:0] d);
    for (int i = 0; i < 4; i++) begin
      logic [11:0] la;
      la = ad + 12'(i);
      if (s[i]) mem_model[la] = d[8*i +: 8];
    end
  endtask

  // Same-edge access: both reads see old data, then B writes, then A (A wins).
  task automatic model_step(
    input bit aen, input bit aw, input logic [3:0] as_, input logic [11:0] aad, input logic [31:0] ad,
    input bit ben, input bit bw, input logic [3:0] bs_, input logic [11:0] bad_, input logic [31:0] bd,
    output logic [31:0] ea, output logic [31:0] eb);
    ea = aen ? model_read(aad, as_) : '0;
    eb = ben ? model_read(bad_, bs_) : '0;
    if (ben && bw) model_write(bad_, bs_, bd);
    if (aen && aw) model_write(aad, as_, ad);
  endtask

  // Launch requests on either/both ports at the same edge and collect acks.
  task automatic xact2(
    input bit aen, input bit aw, input logic [3:0] as_, input logic [11:0] aad, input logic [31:0] ad,
    input bit ben, input bit bw, input logic [3:0] bs_, input logic [11:0] bad_, input logic [31:0] bd,
    output logic [31:0] ra, output int la, output logic [31:0] rb, output int lb, output bit stray);
    ra = '0; rb = '0; la = 0; lb = 0; stray = 1'b0;
    @(negedge clock);
    if (aen) begin a_cyc = 1; a_stb = 1; a_we = aw; a_sel = as_; a_addr = aad; a_dat_i = ad; end
    if (ben) begin b_cyc = 1; b_stb = 1; b_we = bw; b_sel = bs_; b_addr = bad_; b_dat_i = bd; end
    @(posedge clock);
    #1;
    a_cyc = 0; a_stb = 0; b_cyc = 0; b_stb = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (a_ack) begin
        if (aen && la == 0) begin la = k; ra = a_dat_o; end
        else stray = 1'b1;
      end else if (a_dat_o !== '0) stray = 1'b1;
      if (b_ack) begin
        if (ben && lb == 0) begin lb = k; rb = b_dat_o; end
        else stray = 1'b1;
      end else if (b_dat_o !== '0) stray = 1'b1;
      if ((!aen || la != 0) && (!ben || lb != 0)) break;
    end
    @(negedge clock);
    if (a_ack || b_ack || a_dat_o !== '0 || b_dat_o !== '0) stray = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 0;
    a_cyc = 0; a_stb = 0; a_we = 0; a_sel = '0; a_addr = '0; a_dat_i = '0;
    b_cyc = 0; b_stb = 0; b_we = 0; b_sel = '0; b_addr = '0; b_dat_i = '0;
    repeat (3) @(negedge clock);
    total++; if (a_ack !== 1'b0) begin bad++; $display("FAIL reset_a_ack got=%b exp=0", a_ack); end
    total++; if (b_ack !== 1'b0) begin bad++; $display("FAIL reset_b_ack got=%b exp=0", b_ack); end
    total++; if (a_dat_o !== 32'h0) begin bad++; $display("FAIL reset_a_dat got=%h exp=0", a_dat_o); end
    total++; if (b_dat_o !== 32'h0) begin bad++; $display("FAIL reset_b_dat got=%h exp=0", b_dat_o); end
    reset_n = 1;
    @(negedge clock);
  endtask

  // Zero a known window (0x000-0x10F and 0xFF0-0xFFF) so every later read is defined.
  task automatic init_memory();
    logic [31:0] ra, rb, ea, eb;
    int la, lb;
    bit st;
    int timeouts = 0;
    for (int w = 0; w < 12'h110; w += 8) begin
      model_step(1, 1, 4'hF, 12'(w), '0, 1, 1, 4'hF, 12'(w + 4), '0, ea, eb);
      xact2(1, 1, 4'hF, 12'(w), '0, 1, 1, 4'hF, 12'(w + 4), '0, ra, la, rb, lb, st);
      if (la == 0 || lb == 0) timeouts++;
    end
    for (int w = 12'hFF0; w < 12'hFFF; w += 8) begin
      model_step(1, 1, 4'hF, 12'(w), '0, 1, 1, 4'hF, 12'(w + 4), '0, ea, eb);
      xact2(1, 1, 4'hF, 12'(w), '0, 1, 1, 4'hF, 12'(w + 4), '0, ra, la, rb, lb, st);
      if (la == 0 || lb == 0) timeouts++;
    end
    total++; if (timeouts != 0) begin bad++; $display("FAIL init_acks got=%0d timeouts exp=0", timeouts); end
  endtask

  task automatic test_port_a();
    logic [31:0] ra, rb, ea, eb;
    int la, lb;
    bit st;
    model_step(1, 1, 4'hF, 12'h010, 32'hDEADBEEF, 0, 0, '0, '0, '0, ea, eb);
    xact2(1, 1, 4'hF, 12'h010, 32'hDEADBEEF, 0, 0, '0, '0, '0, ra, la, rb, lb, st);
    total++; if (la != LAT_A) begin bad++; $display("FAIL a_wr_latency got=%0d exp=%0d", la, LAT_A); end
    total++; if (ra !== ea) begin bad++; $display("FAIL a_wr_readback got=%h exp=%h", ra, ea); end
    total++; if (st) begin bad++; $display("FAIL a_wr_idle_outputs got=1 exp=0"); end
    xact2(1, 0, 4'hF, 12'h010, '0, 0, 0, '0, '0, '0, ra, la, rb, lb, st);
    total++; if (la != LAT_A) begin bad++; $display("FAIL a_rd_latency got=%0d exp=%0d", la, LAT_A); end
    total++; if (ra !== 32'hDEADBEEF) begin bad++; $display("FAIL a_rd_data got=%h exp=deadbeef", ra); end
    total++; if (st) begin bad++; $display("FAIL a_rd_idle_outputs got=1 exp=0"); end
  endtask

  task automatic test_partial_b();
    logic [31:0] ra, rb, ea, eb;
    int la, lb;
    bit st;
    model_step(0, 0, '0, '0, '0, 1, 1, 4'b0101, 12'h020, 32'h11223344, ea, eb);
    xact2(0, 0, '0, '0, '0, 1, 1, 4'b0101, 12'h020, 32'h11223344, ra, la, rb, lb, st);
    total++; if (lb != LAT_B) begin bad++; $display("FAIL b_wr_latency got=%0d exp=%0d", lb, LAT_B); end
    xact2(0, 0, '0, '0, '0, 1, 0, 4'hF, 12'h020, '0, ra, la, rb, lb, st);
    total++; if (rb !== 32'h00220044) begin bad++; $display("FAIL b_partial_full got=%h exp=00220044", rb); end
    xact2(0, 0, '0, '0, '0, 1, 0, 4'b0011, 12'h020, '0, ra, la, rb, lb, st);
    total++; if (rb !== 32'h00000044) begin bad++; $display("FAIL b_partial_low got=%h exp=00000044", rb); end
    total++; if (st) begin bad++; $display("FAIL b_partial_idle_outputs got=1 exp=0"); end
  endtask

  task automatic test_wrap();
    logic [31:0] ra, rb, ea, eb;
    int la, lb;
    bit st;
    model_step(1, 1, 4'hF, 12'hFFE, 32'hAABBCCDD, 0, 0, '0, '0, '0, ea, eb);
    xact2(1, 1, 4'hF, 12'hFFE, 32'hAABBCCDD, 0, 0, '0, '0, '0, ra, la, rb, lb, st);
    xact2(0, 0, '0, '0, '0, 1, 0, 4'hF, 12'hFFE, '0, ra, la, rb, lb, st);
    total++; if (rb !== 32'hAABBCCDD) begin bad++; $display("FAIL wrap_word got=%h exp=aabbccdd", rb); end
    xact2(0, 0, '0, '0, '0, 1, 0, 4'b0011, 12'h000, '0, ra, la, rb, lb, st);
    total++; if (rb !== 32'h0000AABB) begin bad++; $display("FAIL wrap_low_bytes got=%h exp=0000aabb", rb); end
    xact2(0, 0, '0, '0, '0, 1, 0, 4'b0001, 12'hFFF, '0, ra, la, rb, lb, st);
    total++; if (rb !== 32'h000000CC) begin bad++; $display("FAIL wrap_top_byte got=%h exp=000000cc", rb); end
  endtask

  task automatic test_collision();
    logic [31:0] ra, rb, ea, eb;
    int la, lb;
    bit st;
    model_step(1, 1, 4'hF, 12'h040, 32'h01010101, 1, 1, 4'hF, 12'h040, 32'h02020202, ea, eb);
    xact2(1, 1, 4'hF, 12'h040, 32'h01010101, 1, 1, 4'hF, 12'h040, 32'h02020202, ra, la, rb, lb, st);
    total++; if (la != LAT_A || lb != LAT_B) begin bad++; $display("FAIL coll_latency got=%0d/%0d exp=%0d/%0d", la, lb, LAT_A, LAT_B); end
    xact2(0, 0, '0, '0, '0, 1, 0, 4'hF, 12'h040, '0, ra, la, rb, lb, st);
    total++; if (rb !== 32'h01010101) begin bad++; $display("FAIL coll_ww_winner got=%h exp=01010101", rb); end
    model_step(1, 1, 4'b0001, 12'h050, 32'h00000055, 1, 0, 4'hF, 12'h050, '0, ea, eb);
    xact2(1, 1, 4'b0001, 12'h050, 32'h00000055, 1, 0, 4'hF, 12'h050, '0, ra, la, rb, lb, st);
    total++; if (rb !== 32'h00000000) begin bad++; $display("FAIL coll_rw_old got=%h exp=00000000", rb); end
    xact2(0, 0, '0, '0, '0, 1, 0, 4'hF, 12'h050, '0, ra, la, rb, lb, st);
    total++; if (rb !== 32'h00000055) begin bad++; $display("FAIL coll_rw_after got=%h exp=00000055", rb); end
  endtask

  task automatic test_reset_busy();
    logic [31:0] ra, rb, d;
    int la, lb;
    bit st;
    bit ack_seen = 1'b0;
    bit dat_nz = 1'b0;
    d = $urandom;
    @(negedge clock);
    a_cyc = 1; a_stb = 1; a_we = 1; a_sel = 4'hF; a_addr = 12'h060; a_dat_i = d;
    @(posedge clock);
    #1;
    a_cyc = 0; a_stb = 0;
    model_write(12'h060, 4'hF, d);
    @(negedge clock);
    reset_n = 0;
    repeat (3) begin
      @(negedge clock);
      if (a_ack) ack_seen = 1'b1;
      if (a_dat_o !== '0) dat_nz = 1'b1;
    end
    reset_n = 1;
    repeat (6) begin
      @(negedge clock);
      if (a_ack) ack_seen = 1'b1;
      if (a_dat_o !== '0) dat_nz = 1'b1;
    end
    total++; if (ack_seen) begin bad++; $display("FAIL rst_busy_ack got=1 exp=0"); end
    total++; if (dat_nz) begin bad++; $display("FAIL rst_busy_dat got=nonzero exp=0"); end
    xact2(1, 0, 4'hF, 12'h060, '0, 0, 0, '0, '0, '0, ra, la, rb, lb, st);
    total++; if (ra !== model_read(12'h060, 4'hF)) begin bad++; $display("FAIL rst_busy_committed got=%h exp=%h", ra, model_read(12'h060, 4'hF)); end
  endtask

  task automatic test_throughput();
    logic [31:0] exp_word;
    logic        exp_ack;
    exp_word = model_read(12'h010, 4'hF);
    @(negedge clock);
    b_cyc = 1; b_stb = 1; b_we = 0; b_sel = 4'hF; b_addr = 12'h010; b_dat_i = '0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      exp_ack = (k % 2 == 1);
      total++; if (b_ack !== exp_ack) begin bad++; $display("FAIL tput_ack[%0d] got=%b exp=%b", k, b_ack, exp_ack); end
      total++; if (b_dat_o !== (exp_ack ? exp_word : 32'h0)) begin bad++; $display("FAIL tput_dat[%0d] got=%h exp=%h", k, b_dat_o, exp_ack ? exp_word : 32'h0); end
    end
    b_cyc = 0; b_stb = 0;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_random();
    logic [31:0] ra, rb, ea, eb, ad, bd;
    logic [11:0] aad, bad_;
    logic [3:0]  as_, bs_;
    bit aen, ben, aw, bw, st;
    int la, lb;
    for (int it = 0; it < 30; it++) begin
      aen = $urandom_range(0, 1);
      ben = aen ? 1'($urandom_range(0, 1)) : 1'b1;
      aw = $urandom_range(0, 1); bw = $urandom_range(0, 1);
      as_ = 4'($urandom); bs_ = 4'($urandom);
      ad = $urandom; bd = $urandom;
      aad  = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(0, 255)) : 12'($urandom_range(12'hFF0, 12'hFFF));
      bad_ = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(0, 255)) : 12'($urandom_range(12'hFF0, 12'hFFF));
      model_step(aen, aw, as_, aad, ad, ben, bw, bs_, bad_, bd, ea, eb);
      xact2(aen, aw, as_, aad, ad, ben, bw, bs_, bad_, bd, ra, la, rb, lb, st);
      if (aen) begin
        total++; if (la != LAT_A) begin bad++; $display("FAIL rnd_a_lat[%0d] got=%0d exp=%0d", it, la, LAT_A); end
        total++; if (ra !== ea) begin bad++; $display("FAIL rnd_a_dat[%0d] got=%h exp=%h", it, ra, ea); end
      end
      if (ben) begin
        total++; if (lb != LAT_B) begin bad++; $display("FAIL rnd_b_lat[%0d] got=%0d exp=%0d", it, lb, LAT_B); end
        total++; if (rb !== eb) begin bad++; $display("FAIL rnd_b_dat[%0d] got=%h exp=%h", it, rb, eb); end
      end
      total++; if (st) begin bad++; $display("FAIL rnd_idle_outputs[%0d] got=1 exp=0", it); end
    end
  endtask

  initial begin
    test_reset();
    init_memory();
    test_port_a();
    test_partial_b();
    test_wrap();
    test_collision();
    test_reset_busy();
    test_throughput();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
